free_list: RTL and testbench

- Physical-register free list for the rename stage. It consumes the ROB commit stream (commit valid plus old physical register) and recycles those registers.
- Supplies new destination physical registers to rename/dispatch in program order.
- Holds a single branch checkpoint of its read pointer so a branch mispredict restores the wrong-path allocations in one cycle, mirroring the ROB's single tail shadow.

---
 rtl/rename_pkg.sv | 13 +
 rtl/free_list.sv | 127 ++++++++++++
 tb/tb_free_list.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Rename-stage shared types: physical register sizing used by the
// free list, ROB and rename map.
package rename_pkg;

  localparam int PREG_WIDTH = 7;
  localparam int NUM_PREGS  = 1 << PREG_WIDTH;
  localparam int NUM_AREGS  = 32;
  localparam int NUM_FREE0  = NUM_PREGS - NUM_AREGS;

  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [PREG_WIDTH:0]   pcnt_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list with a single branch checkpoint.
// Optional FREE_LIST_DUP_CHECK_EN adds double-free detection.
module free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_alloc_req,
  output logic  o_alloc_valid,
  output preg_t o_alloc_preg,
  input  logic  i_commit_valid,
  input  preg_t i_commit_old_preg,
  input  logic  i_branch_dispatch,
  input  logic  i_branch_mispredict,
  output logic  o_empty,
  output pcnt_t o_count,
  output logic  o_double_free
);

  preg_t mem_q [NUM_PREGS];
  preg_t rd_ptr_q, rd_ptr_d;
  preg_t wr_ptr_q, wr_ptr_d;
  preg_t shadow_q, shadow_d;
  pcnt_t count_q, count_d;

  logic pop;
  logic push_req;
  logic push;
  preg_t rd_ptr_nx;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] is_free_q, is_free_d;
  logic dup;
  logic dbl_q, dbl_d;
  preg_t squash_n;
`endif

  assign pop = i_alloc_req && (count_q != '0)
             && !i_branch_mispredict;
  assign push_req = i_commit_valid
                  && (i_commit_old_preg != '0);

`ifdef FREE_LIST_DUP_CHECK_EN
  assign dup  = push_req && is_free_q[i_commit_old_preg];
  assign push = push_req && !dup;
`else
  assign push = push_req;
`endif

  assign rd_ptr_nx = rd_ptr_q + preg_t'(pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + preg_t'(push);
    rd_ptr_d = rd_ptr_nx;
    shadow_d = shadow_q;
    count_d  = count_q + pcnt_t'(push) - pcnt_t'(pop);
    if (i_branch_mispredict) begin
      rd_ptr_d = shadow_q;
      count_d  = {1'b0, wr_ptr_d - shadow_q};
    end else if (i_branch_dispatch) begin
      shadow_d = rd_ptr_nx;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  // Wrong-path pregs sit between the snapshot and the read pointer.
  assign squash_n = rd_ptr_q - shadow_q;

  always_comb begin
    is_free_d = is_free_q;
    dbl_d     = dbl_q | dup;
    if (pop)
      is_free_d[mem_q[rd_ptr_q]] = 1'b0;
    if (i_branch_mispredict) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        if (preg_t'(i) < squash_n)
          is_free_d[mem_q[shadow_q + preg_t'(i)]] = 1'b1;
      end
    end
    if (push)
      is_free_d[i_commit_old_preg] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        is_free_q[i] <= (i >= NUM_AREGS);
      dbl_q <= 1'b0;
    end else begin
      is_free_q <= is_free_d;
      dbl_q     <= dbl_d;
    end
  end

  assign o_double_free = dbl_q;
`else
  assign o_double_free = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        if (i < NUM_FREE0)
          mem_q[i] <= preg_t'(NUM_AREGS + i);
        else
          mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= preg_t'(NUM_FREE0);
      shadow_q <= '0;
      count_q  <= pcnt_t'(NUM_FREE0);
    end else begin
      if (push)
        mem_q[wr_ptr_q] <= i_commit_old_preg;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign o_alloc_valid = (count_q != '0);
  assign o_alloc_preg  = mem_q[rd_ptr_q];
  assign o_empty       = (count_q == '0);
  assign o_count       = count_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: drain, recycle, bypass-free empty,
// checkpoint restore and double-free behaviour.
module tb_free_list;
  import rename_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  alloc_req;
  logic  alloc_valid;
  preg_t alloc_preg;
  logic  commit_valid;
  preg_t commit_preg;
  logic  br_disp;
  logic  br_misp;
  logic  empty;
  pcnt_t count;
  logic  dbl;

  int n_tests = 0;
  int n_fail  = 0;

  free_list dut (
    .clk                (clk),
    .reset              (reset),
    .i_alloc_req        (alloc_req),
    .o_alloc_valid      (alloc_valid),
    .o_alloc_preg       (alloc_preg),
    .i_commit_valid     (commit_valid),
    .i_commit_old_preg  (commit_preg),
    .i_branch_dispatch  (br_disp),
    .i_branch_mispredict(br_misp),
    .o_empty            (empty),
    .o_count            (count),
    .o_double_free      (dbl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req    = 1'b0;
    commit_valid = 1'b0;
    commit_preg  = '0;
    br_disp      = 1'b0;
    br_misp      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic commit(input int p);
    commit_valid = 1'b1;
    commit_preg  = preg_t'(p);
    tick();
    idle();
  endtask

  task automatic alloc_expect(input string tag, input int p);
    alloc_req = 1'b1;
    check(tag, int'(alloc_preg), p);
    tick();
    idle();
  endtask

  initial begin
    do_reset();
    check("rst_valid", int'(alloc_valid), 1);
    check("rst_preg", int'(alloc_preg), 32);
    check("rst_empty", int'(empty), 0);
    check("rst_count", int'(count), 96);
    check("rst_dbl", int'(dbl), 0);

    // Drain the full reset list
    for (int i = 0; i < 96; i++)
      alloc_expect("drain_preg", 32 + i);
    check("drain_empty", int'(empty), 1);
    check("drain_count", int'(count), 0);
    alloc_req = 1'b1;
    check("empty_valid", int'(alloc_valid), 0);
    tick();
    idle();
    check("empty_count", int'(count), 0);

    // Commits of preg 0 are not pushed
    commit(0);
    check("c0_count_a", int'(count), 0);
    commit(0);
    check("c0_count_b", int'(count), 0);
    commit(5);
    check("c5_count", int'(count), 1);
    check("c5_valid", int'(alloc_valid), 1);
    alloc_expect("c5_preg", 5);
    check("c5_drained", int'(count), 0);

    // Empty plus same-cycle push: no bypass
    alloc_req    = 1'b1;
    commit_valid = 1'b1;
    commit_preg  = 7;
    #1;
    check("nobyp_valid", int'(alloc_valid), 0);
    tick();
    idle();
    check("nobyp_valid_nx", int'(alloc_valid), 1);
    check("nobyp_preg_nx", int'(alloc_preg), 7);
    check("nobyp_count", int'(count), 1);
    alloc_expect("nobyp_alloc", 7);

    // Simultaneous push and pop at count 10
    for (int i = 0; i < 10; i++)
      commit(10 + i);
    check("pp_pre_count", int'(count), 10);
    alloc_req    = 1'b1;
    commit_valid = 1'b1;
    commit_preg  = 40;
    #1;
    check("pp_head", int'(alloc_preg), 10);
    tick();
    idle();
    check("pp_count", int'(count), 10);
    check("pp_head_nx", int'(alloc_preg), 11);
    for (int i = 0; i < 9; i++)
      alloc_expect("pp_drain", 11 + i);
    check("pp_tail", int'(alloc_preg), 40);
    check("pp_tail_cnt", int'(count), 1);

    // Checkpoint and restore
    do_reset();
    br_disp   = 1'b1;
    alloc_req = 1'b1;
    check("br_own", int'(alloc_preg), 32);
    tick();
    idle();
    alloc_expect("br_wp0", 33);
    alloc_expect("br_wp1", 34);
    alloc_expect("br_wp2", 35);
    check("br_cnt_pre", int'(count), 92);
    br_misp      = 1'b1;
    br_disp      = 1'b1;
    alloc_req    = 1'b1;
    commit_valid = 1'b1;
    commit_preg  = 9;
    tick();
    idle();
    check("br_rest_preg", int'(alloc_preg), 33);
    check("br_rest_cnt", int'(count), 96);
    // Dispatch during mispredict was ignored
    alloc_expect("br_again0", 33);
    alloc_expect("br_again1", 34);
    br_misp = 1'b1;
    tick();
    idle();
    check("br2_preg", int'(alloc_preg), 33);
    check("br2_cnt", int'(count), 96);

    // Reset discards the snapshot
    alloc_expect("rs_a0", 33);
    br_disp   = 1'b1;
    alloc_req = 1'b1;
    tick();
    idle();
    do_reset();
    alloc_expect("rs_b0", 32);
    alloc_expect("rs_b1", 33);
    br_misp = 1'b1;
    tick();
    idle();
    check("rs_preg", int'(alloc_preg), 32);
    check("rs_cnt", int'(count), 96);

    // Double free of a preg that is still free
    do_reset();
    commit(50);
`ifdef FREE_LIST_DUP_CHECK_EN
    check("dup_flag", int'(dbl), 1);
    check("dup_count", int'(count), 96);
    commit(3);
    check("dup_sticky", int'(dbl), 1);
    check("dup_ok_cnt", int'(count), 97);
`else
    check("dup_flag", int'(dbl), 0);
    check("dup_count", int'(count), 97);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
